// File: rtl/trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trap_ctrl : machine-mode trap entry / mret sequencer in front of csr_regfile |
// | rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module trap_ctrl #(
  parameter int DATA_W = 32,
  parameter bit IRQ_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_csr_we_i,
  input  logic [11:0]       ex_csr_waddr_i,
  input  logic [DATA_W-1:0] ex_csr_wdata_i,
  input  logic              ex_valid_i,
  input  logic [DATA_W-1:0] ex_pc_i,
  input  logic              ex_ecall_i,
  input  logic              ex_ebreak_i,
  input  logic              ex_illegal_i,
  input  logic              ex_mret_i,
  input  logic              irq_timer_i,
  input  logic              irq_ext_i,
  input  logic [DATA_W-1:0] mstatus_i,
  input  logic [DATA_W-1:0] mie_i,
  input  logic [DATA_W-1:0] mtvec_i,
  input  logic [DATA_W-1:0] mepc_i,
  output logic              csr_we_o,
  output logic [11:0]       csr_waddr_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  output logic              hold_o,
  output logic              jump_o,
  output logic [DATA_W-1:0] jump_addr_o,
  output logic              busy_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;
  localparam int MEIE_BIT = 11;

  localparam logic [DATA_W-1:0] CAUSE_ILLEGAL = DATA_W'(2);
  localparam logic [DATA_W-1:0] CAUSE_EBREAK  = DATA_W'(3);
  localparam logic [DATA_W-1:0] CAUSE_ECALL   = DATA_W'(11);
  localparam logic [DATA_W-1:0] CAUSE_IRQ_EXT = {1'b1, {(DATA_W-5){1'b0}}, 4'hB};
  localparam logic [DATA_W-1:0] CAUSE_IRQ_TMR = {1'b1, {(DATA_W-5){1'b0}}, 4'h7};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    T_MEPC    = 3'd1,
    T_MCAUSE  = 3'd2,
    T_MSTATUS = 3'd3,
    T_JUMP    = 3'd4,
    R_MSTATUS = 3'd5,
    R_JUMP    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [DATA_W-1:0] epc_q, epc_d;

  logic              irq_ext_take;
  logic              irq_tmr_take;
  logic              evt;
  logic              evt_is_mret;
  logic [DATA_W-1:0] evt_cause;
  logic [DATA_W-1:0] mstatus_trap;
  logic [DATA_W-1:0] mstatus_ret;

  // Only a handful of mie/mtvec bits are meaningful here.
  logic unused_taps;
  assign unused_taps = ^{mie_i, mtvec_i[1:0]};

  // Event detection and cause selection, highest priority first.
  always_comb begin
    irq_ext_take = IRQ_EN && mstatus_i[MIE_BIT] && mie_i[MEIE_BIT] && irq_ext_i;
    irq_tmr_take = IRQ_EN && mstatus_i[MIE_BIT] && mie_i[MTIE_BIT] && irq_timer_i;
    evt          = 1'b1;
    evt_is_mret  = 1'b0;
    evt_cause    = '0;
    if (ex_valid_i && ex_illegal_i) begin
      evt_cause = CAUSE_ILLEGAL;
    end else if (ex_valid_i && ex_ebreak_i) begin
      evt_cause = CAUSE_EBREAK;
    end else if (ex_valid_i && ex_ecall_i) begin
      evt_cause = CAUSE_ECALL;
    end else if (ex_valid_i && ex_mret_i) begin
      evt_is_mret = 1'b1;
    end else if (irq_ext_take) begin
      evt_cause = CAUSE_IRQ_EXT;
    end else if (irq_tmr_take) begin
      evt_cause = CAUSE_IRQ_TMR;
    end else begin
      evt = 1'b0;
    end
  end

  always_comb begin
    mstatus_trap           = mstatus_i;
    mstatus_trap[MPIE_BIT] = mstatus_i[MIE_BIT];
    mstatus_trap[MIE_BIT]  = 1'b0;
    mstatus_ret            = mstatus_i;
    mstatus_ret[MIE_BIT]   = mstatus_i[MPIE_BIT];
    mstatus_ret[MPIE_BIT]  = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    hold_o      = 1'b1;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    busy_o      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (evt) begin
          // The EX instruction is flushed, so its CSR write is dropped.
          epc_d   = ex_pc_i;
          cause_d = evt_cause;
          state_d = evt_is_mret ? R_MSTATUS : T_MEPC;
        end else begin
          hold_o      = 1'b0;
          csr_we_o    = ex_csr_we_i;
          csr_waddr_o = ex_csr_waddr_i;
          csr_wdata_o = ex_csr_wdata_i;
        end
      end
      T_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = epc_q;
        state_d     = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_q;
        state_d     = T_MSTATUS;
      end
      T_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mstatus_trap;
        state_d     = T_JUMP;
      end
      T_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = {mtvec_i[DATA_W-1:2], 2'b00};
        state_d     = IDLE;
      end
      R_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mstatus_ret;
        state_d     = R_JUMP;
      end
      R_JUMP: begin
        jump_o      = 1'b1;
        jump_addr_o = mepc_i;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Keep every output quiet while reset is held, even mid-sequence.
    if (rst) begin
      csr_we_o    = 1'b0;
      csr_waddr_o = '0;
      csr_wdata_o = '0;
      hold_o      = 1'b0;
      jump_o      = 1'b0;
      jump_addr_o = '0;
      busy_o      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

endmodule
`default_nettype wire
